async_fifo_wptr_ctl: RTL

Next-generation write-side pointer and full controller for the async FIFO, running entirely in the write clock domain.
- Synchronises the raw Gray read pointer internally through a configurable number of stages.
- Produces the memory write address, the Gray write pointer for the read domain, and registered flags: full, almost-full and optional sticky overflow.
- Reports the write-side fill level.
- Sits between the write client, the dual-port RAM, and the read-pointer block's Gray output.

---
 rtl/async_fifo_wptr_ctl.sv | 111 +++++++++++
 1 files changed

// File: rtl/async_fifo_wptr_ctl.sv
// Write-side pointer, full/almost-full and fill-level controller for the async FIFO (wclk domain).
// Optional sticky overflow flag is built when ASYNC_FIFO_WOVF_EN is defined.
module async_fifo_wptr_ctl #(
  parameter int unsigned ADDRSIZE    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic [ADDRSIZE:0]   afull_lvl,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  localparam int unsigned PW = ADDRSIZE + 1;

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] sync_d [SYNC_STAGES];
  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q, wfull_d;
  logic          walmost_full_q, walmost_full_d;
  logic          wen;
  logic [PW-1:0] wq_rptr;
  logic [PW-1:0] rbin;

  // Plain flop chain bringing the Gray read pointer into wclk
  always_comb begin
    for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
      sync_d[i] = (i == 0) ? rptr : sync_q[i-1];
    end
    wq_rptr = sync_q[SYNC_STAGES-1];
  end

  // Gray-to-binary via XOR prefix from the MSB
  always_comb begin
    rbin         = '0;
    rbin[PW-1]   = wq_rptr[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ wq_rptr[i];
    end
  end

  always_comb begin
    wen            = winc & ~wfull_q;
    wbin_d         = wbin_q + PW'(wen);
    wptr_d         = (wbin_d >> 1) ^ wbin_d;
    // Full when the write pointer is exactly one lap ahead of the synced read pointer
    wfull_d        = (wptr_d == {~wq_rptr[ADDRSIZE:ADDRSIZE-1], wq_rptr[ADDRSIZE-2:0]});
    wlevel_d       = wbin_d - rbin;
    walmost_full_d = (wlevel_d >= afull_lvl);
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      wbin_q         <= '0;
      wptr_q         <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
    end
  end

  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;

`ifdef ASYNC_FIFO_WOVF_EN
  logic wovf_q, wovf_d;

  // Sticky overflow; a dropped write outranks a same-cycle clear
  always_comb begin
    wovf_d = wovf_q;
    if (wovf_clr) wovf_d = 1'b0;
    if (winc & wfull_q) wovf_d = 1'b1;
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) wovf_q <= 1'b0;
    else         wovf_q <= wovf_d;
  end

  assign wovf = wovf_q;
`else
  logic unused_wovf_clr;
  assign unused_wovf_clr = wovf_clr;
  assign wovf            = 1'b0;
`endif

endmodule
